// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the async FIFO write port
// among NUM_REQ producers in the write clock domain. A grant lasts one burst,
// ending on req_last, on MAX_BURST words, or when the requester withdraws.
// Optional macro WARB_STALL_CNT_EN adds a saturating 16-bit stall counter.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
`ifdef WARB_STALL_CNT_EN
  output logic [15:0]                   stall_cnt,
`endif
  output logic [DATA_WIDTH-1:0]         fifo_din
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]   r_burst_cnt;
  logic               r_busy;

  logic [PTR_W-1:0]      w_gidx;
  logic [PTR_W-1:0]      w_next_ptr;
  logic [PTR_W-1:0]      w_sel_idx;
  logic                  w_sel_found;
  logic                  w_gnt_req;
  logic                  w_xfer;
  logic                  w_last;
  logic                  w_cnt_max;
  logic [DATA_WIDTH-1:0] w_din_masked [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_din;

  assign grant      = r_grant;
  assign busy       = r_busy;
  assign w_gnt_req  = |(req & r_grant);
  assign w_xfer     = w_gnt_req & ~fifo_full;
  assign w_last     = |(req_last & r_grant);
  assign w_cnt_max  = (r_burst_cnt == CNT_W'(MAX_BURST - 1));
  assign fifo_wr_en = w_xfer;
  assign ack        = r_grant & {NUM_REQ{w_xfer}};
  assign fifo_din   = w_din;

  // Mask each requester's data by its grant bit; idle grant yields zero data.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_din_mask
      assign w_din_masked[gi] = r_grant[gi] ? req_data[gi*DATA_WIDTH +: DATA_WIDTH]
                                            : '0;
    end
  endgenerate

  // OR the masked slices together to form the FIFO write data.
  always_comb begin
    w_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_din = w_din | w_din_masked[i];
    end
  end

  // Encode the one-hot grant into an index and compute the wrapped successor.
  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) w_gidx = PTR_W'(i);
    end
    w_next_ptr = (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + PTR_W'(1);
  end

  // Scan requests from rr_ptr upward with wrap; scanning downward lets the
  // nearest candidate overwrite the farther ones.
  always_comb begin
    int idx;
    idx         = 0;
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = PTR_W'(idx);
      end
    end
  end

  // Arbitration FSM: grant in IDLE, count/release in BURST, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sel_found) begin
            r_grant     <= NUM_REQ'(1) << w_sel_idx;
            r_burst_cnt <= '0;
            r_state     <= BURST;
            r_busy      <= 1'b1;
          end
        end
        BURST: begin
          if (!w_gnt_req || (w_xfer && (w_last || w_cnt_max))) begin
            r_grant  <= '0;
            r_rr_ptr <= w_next_ptr;
            r_state  <= IDLE;
            r_busy   <= 1'b0;
          end else if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef WARB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  assign stall_cnt = r_stall_cnt;

  // Count cycles where the granted requester is blocked by a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_state == BURST && w_gnt_req && fifo_full && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the write port of the team's asynchronous FIFO among NUM_REQ producers in the write clock domain. Each grant covers a burst that ends on a last-word marker, on a per-grant word limit, or when the requester withdraws. The block drives the FIFO write enable and data, and honours the FIFO full flag. It sits between producer blocks and the FIFO write side; the read side is untouched.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- DATA_WIDTH, 8, FIFO word width
- MAX_BURST, 8, max words per grant (≥1)

- clk  in  1  write-domain clock (same clock as FIFO wr_clk)
- rst_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  requester i has a word ready
- req_data  in  NUM_REQ*DATA_WIDTH  packed; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  current word of requester i ends its burst
- ack  out  NUM_REQ  one-hot; word of requester i written this cycle
- grant  out  NUM_REQ  one-hot registered grant; 0 when idle
- busy  out  1  state is BURST
- fifo_full  in  1  FIFO full flag
- fifo_wr_en  out  1  FIFO write enable
- fifo_din  out  DATA_WIDTH  FIFO write data

## Operation
- States: IDLE, BURST. Registers: state, grant, rr_ptr ($clog2(NUM_REQ) bits), burst_cnt ($clog2(MAX_BURST+1) bits).
- IDLE: if any req is high, select the first i with req[i]=1, scanning from rr_ptr upward and wrapping modulo NUM_REQ. Next edge: grant ← onehot(i), burst_cnt ← 0, state ← BURST. If req=0, stay in IDLE.
- BURST, granted index g. The following are combinational:
  - xfer = req[g] & ~fifo_full
  - fifo_wr_en = xfer
  - ack[g] = xfer, all other ack bits 0
  - fifo_din = req_data slice g (0 when grant=0)
- BURST end: on xfer with req_last[g]=1 or burst_cnt==MAX_BURST-1, next edge sets grant ← 0, rr_ptr ← (g+1) mod NUM_REQ, state ← IDLE. Otherwise, on xfer, burst_cnt increments.
- BURST withdraw: if req[g]=0, no write occurs. Next edge releases the grant as above: rr_ptr ← g+1, state ← IDLE.
- fifo_full=1 with req[g]=1: stall. No write, no ack; grant, burst_cnt and rr_ptr are held.
- req_last and req_data of non-granted requesters are ignored.

## Timing
- Reset values: state=IDLE, grant=0, rr_ptr=0, burst_cnt=0, busy=0, ack=0, fifo_wr_en=0, fifo_din=0.
- Reset is asynchronous. Assertion mid-burst forces grant=0, which drops fifo_wr_en and ack immediately in the same cycle. The interrupted burst is abandoned.
- Latency: req rising in IDLE at cycle N → grant at N+1 → first write possible in cycle N+1.
- Every burst end is followed by exactly one IDLE cycle, so there are no back-to-back grants.
- Maximum write throughput: 1 word/cycle within a burst.
- The FIFO samples fifo_wr_en/fifo_din at the same clk edge that updates the arbiter state. A requester treats a word as consumed on the edge where ack[i]=1, and presents its next word (or drops req) after that edge.
- rr_ptr wraps from NUM_REQ-1 to 0. For non-power-of-2 NUM_REQ, the increment uses explicit compare-and-clear.

## Configuration
- WARB_STALL_CNT_EN defined:
  - Adds output stall_cnt, 16 bits, reset 0.
  - Increments each cycle with state=BURST, req[g]=1 and fifo_full=1.
  - Saturates at 16'hFFFF and is never cleared except by rst_n.
- WARB_STALL_CNT_EN undefined: port and counter are absent. Behaviour is otherwise identical.

## Test plan
- Single burst: req[1] from cycle 0, req_last[1] on the 3rd word → grant=0010 in cycles 1–3, fifo_wr_en=1 in cycles 1–3, grant=0 and busy=0 in cycle 4.
- Round-robin: req=1111 held, req_last=0, MAX_BURST=8 → grant sequence 0,1,2,3,0, each grant giving 8 writes, with one idle cycle between grants.
- Full stall: fifo_full=1 for 5 cycles after the 2nd word of a burst → fifo_wr_en=0, ack=0, grant held; burst resumes at word 3. With the macro defined, stall_cnt=5.
- Withdraw: req[2] drops after 2 written words → no write that cycle, grant=0 next cycle, next grant goes to requester 3 when req=1111.
- Reset mid-burst: rst_n low during a burst of requester 1 → grant=0 and fifo_wr_en=0 with no clock edge. After release, with only req[3]=1 → grant=1000 one cycle later.
- Burst cap: req[0]=1 with req_last never asserted → exactly MAX_BURST acks, then release; re-grant to 0 after the idle cycle if it is the only requester.
